// File: rtl/fwd_stream_sequencer.sv
// Streams the guess vector plus bias into the forward engine, then collects the
// serial per-function results and the accumulated error for the trainer.
module fwd_stream_sequencer #(
  parameter int unsigned NUM_UNKNOWNS   = 2,
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned EXTRA_BITS     = 2,
  parameter int unsigned RESULT_LATENCY = 6,
  parameter logic [BIT_WIDTH+EXTRA_BITS-1:0] BIAS_VALUE = 34'h13F800000,
  localparam int unsigned W  = BIT_WIDTH + EXTRA_BITS,
  localparam int unsigned AW = (NUM_UNKNOWNS > 1) ? $clog2(NUM_UNKNOWNS) : 1,
  localparam int unsigned CW = $clog2(RESULT_LATENCY + NUM_UNKNOWNS + 2)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          GUESS_WR_EN,
  input  logic [AW-1:0] GUESS_WR_ADDR,
  input  logic [W-1:0]  GUESS_WR_DATA,
  input  logic          START,
  output logic [W-1:0]  INPUT_SCALER,
  output logic          SCALER_VALID,
  output logic          INITIAL_READ_FLAG,
  input  logic [W-1:0]  ENGINE_RESULT,
  input  logic [W-1:0]  ENGINE_ERROR,
  output logic          BUSY,
  output logic          RESULT_VALID,
  output logic [AW-1:0] RESULT_IDX,
  output logic [W-1:0]  RESULT_DATA,
  output logic [W-1:0]  ERROR_OUT,
  output logic          DONE,
  output logic          WR_DROP
);

  localparam logic [CW-1:0] LastBeat = CW'(NUM_UNKNOWNS);
  localparam logic [CW-1:0] FirstRes = CW'(RESULT_LATENCY);
  localparam logic [CW-1:0] LastRes  = CW'(RESULT_LATENCY + NUM_UNKNOWNS - 1);

  typedef enum logic [2:0] {StIdle, StStream, StWait, StCollect, StErr} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d, cyc_inc;
  logic [W-1:0]  guess_q [NUM_UNKNOWNS];
  logic          capture_res, capture_err, wr_accept;

  logic          res_valid_q, done_q, wr_drop_q;
  logic [AW-1:0] res_idx_q;
  logic [W-1:0]  res_data_q, err_q;

  assign cyc_inc   = cyc_q + CW'(1);
  assign BUSY      = (state_q != StIdle);
  assign wr_accept = GUESS_WR_EN && !BUSY && (32'(GUESS_WR_ADDR) < NUM_UNKNOWNS);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StStream;
          cyc_d   = '0;
        end
      end
      StStream: begin
        cyc_d = cyc_inc;
        // Minimum latency leaves no wait cycles between the bias beat and f_0.
        if (cyc_q == LastBeat) state_d = (cyc_inc == FirstRes) ? StCollect : StWait;
      end
      StWait: begin
        cyc_d = cyc_inc;
        if (cyc_inc == FirstRes) state_d = StCollect;
      end
      StCollect: begin
        cyc_d = cyc_inc;
        if (cyc_q == LastRes) state_d = StErr;
      end
      StErr: begin
        cyc_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cyc_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    INPUT_SCALER      = '0;
    SCALER_VALID      = 1'b0;
    INITIAL_READ_FLAG = 1'b0;
    capture_res       = 1'b0;
    capture_err       = 1'b0;
    case (state_q)
      StStream: begin
        SCALER_VALID      = 1'b1;
        INITIAL_READ_FLAG = (cyc_q == '0);
        INPUT_SCALER      = (cyc_q == LastBeat) ? BIAS_VALUE : guess_q[cyc_q[AW-1:0]];
      end
      StCollect: capture_res = 1'b1;
      StErr:     capture_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_UNKNOWNS; i++) guess_q[i] <= '0;
    end else if (wr_accept) begin
      guess_q[GUESS_WR_ADDR] <= GUESS_WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
      err_q       <= '0;
      done_q      <= 1'b0;
      wr_drop_q   <= 1'b0;
    end else begin
      res_valid_q <= capture_res;
      done_q      <= capture_err;
      wr_drop_q   <= GUESS_WR_EN && !wr_accept;
      if (capture_res) begin
        res_data_q <= ENGINE_RESULT;
        res_idx_q  <= (cyc_q == FirstRes) ? '0 : res_idx_q + AW'(1);
      end
      if (capture_err) err_q <= ENGINE_ERROR;
    end
  end

  assign RESULT_VALID = res_valid_q;
  assign RESULT_IDX   = res_idx_q;
  assign RESULT_DATA  = res_data_q;
  assign ERROR_OUT    = err_q;
  assign DONE         = done_q;
  assign WR_DROP      = wr_drop_q;

endmodule

// File: tb/tb_fwd_stream_sequencer.sv
// Directed, table-driven bench for fwd_stream_sequencer (N=2, latency 6).
module tb_fwd_stream_sequencer;

  localparam int W  = 34;
  localparam int NV = 24;
  localparam logic [W-1:0] BIAS = 34'h13F800000;
  localparam logic [W-1:0] G1   = 34'h13F800000;
  localparam logic [W-1:0] G2   = 34'h140000000;
  localparam logic [W-1:0] G3   = 34'h140800000;
  localparam logic [W-1:0] R0   = 34'h140400000;
  localparam logic [W-1:0] R1   = 34'h1C0800000;
  localparam logic [W-1:0] E0   = 34'h141500000;
  localparam logic [W-1:0] JUNK = 34'h3DEADBEEF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en, start;
  logic [0:0]   wr_addr;
  logic [W-1:0] wr_data, eng_res, eng_err;
  logic [W-1:0] scaler, rdata, err_out;
  logic         svalid, init_flag, busy, rvalid, done, wr_drop;
  logic [0:0]   ridx;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         wr_en;
    logic [0:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         start;
    logic [W-1:0] eng_res;
    logic [W-1:0] eng_err;
    logic [W-1:0] x_scaler;
    logic         x_svalid;
    logic         x_init;
    logic         x_busy;
    logic         x_rvalid;
    logic [0:0]   x_idx;
    logic [W-1:0] x_rdata;
    logic [W-1:0] x_err;
    logic         x_done;
    logic         x_drop;
  } vec_t;

  vec_t vecs [NV];
  vec_t zero_vec;

  fwd_stream_sequencer #(
    .NUM_UNKNOWNS  (2),
    .BIT_WIDTH     (32),
    .EXTRA_BITS    (2),
    .RESULT_LATENCY(6),
    .BIAS_VALUE    (BIAS)
  ) dut (
    .CLK              (clk),
    .RESET            (rst_n),
    .GUESS_WR_EN      (wr_en),
    .GUESS_WR_ADDR    (wr_addr),
    .GUESS_WR_DATA    (wr_data),
    .START            (start),
    .INPUT_SCALER     (scaler),
    .SCALER_VALID     (svalid),
    .INITIAL_READ_FLAG(init_flag),
    .ENGINE_RESULT    (eng_res),
    .ENGINE_ERROR     (eng_err),
    .BUSY             (busy),
    .RESULT_VALID     (rvalid),
    .RESULT_IDX       (ridx),
    .RESULT_DATA      (rdata),
    .ERROR_OUT        (err_out),
    .DONE             (done),
    .WR_DROP          (wr_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " INPUT_SCALER"},      scaler,    v.x_scaler);
    chk({tag, " SCALER_VALID"},      svalid,    W'(v.x_svalid));
    chk({tag, " INITIAL_READ_FLAG"}, init_flag, W'(v.x_init));
    chk({tag, " BUSY"},              busy,      W'(v.x_busy));
    chk({tag, " RESULT_VALID"},      rvalid,    W'(v.x_rvalid));
    chk({tag, " RESULT_IDX"},        W'(ridx),  W'(v.x_idx));
    chk({tag, " RESULT_DATA"},       rdata,     v.x_rdata);
    chk({tag, " ERROR_OUT"},         err_out,   v.x_err);
    chk({tag, " DONE"},              done,      W'(v.x_done));
    chk({tag, " WR_DROP"},           wr_drop,   W'(v.x_drop));
  endtask

  task automatic drive(input vec_t v);
    wr_en   = v.wr_en;
    wr_addr = v.wr_addr;
    wr_data = v.wr_data;
    start   = v.start;
    eng_res = v.eng_res;
    eng_err = v.eng_err;
  endtask

  initial begin
    zero_vec = '{default: '0};
    for (int i = 0; i < NV; i++) vecs[i] = '{default: '0};

    // Stimulus: step index = clock cycle; a run started in step s has beat 0 in step s+1.
    vecs[0].wr_en = 1'b1;  vecs[0].wr_addr = 1'b0;  vecs[0].wr_data = G1;
    vecs[1].wr_en = 1'b1;  vecs[1].wr_addr = 1'b1;  vecs[1].wr_data = G2;
    vecs[2].start = 1'b1;
    vecs[5].start = 1'b1;
    vecs[6].wr_en = 1'b1;  vecs[6].wr_addr = 1'b0;  vecs[6].wr_data = '0;
    vecs[9].eng_res  = R0;
    vecs[10].eng_res = R1; vecs[10].eng_err = JUNK;
    vecs[11].eng_res = JUNK; vecs[11].eng_err = E0;
    vecs[12].start = 1'b1;
    vecs[12].wr_en = 1'b1; vecs[12].wr_addr = 1'b1; vecs[12].wr_data = G3;
    vecs[19].eng_res = R1;
    vecs[20].eng_res = R0;
    vecs[21].eng_err = G3;
    vecs[22].eng_res = JUNK; vecs[22].eng_err = JUNK;

    // Expected outputs.
    for (int i = 3; i <= 11; i++) vecs[i].x_busy = 1'b1;
    for (int i = 13; i <= 21; i++) vecs[i].x_busy = 1'b1;
    vecs[3].x_scaler  = G1;   vecs[4].x_scaler  = G2; vecs[5].x_scaler  = BIAS;
    vecs[13].x_scaler = G1;   vecs[14].x_scaler = G3; vecs[15].x_scaler = BIAS;
    for (int i = 3; i <= 5; i++) vecs[i].x_svalid = 1'b1;
    for (int i = 13; i <= 15; i++) vecs[i].x_svalid = 1'b1;
    vecs[3].x_init  = 1'b1;
    vecs[13].x_init = 1'b1;
    vecs[7].x_drop  = 1'b1;
    vecs[10].x_rvalid = 1'b1; vecs[11].x_rvalid = 1'b1;
    vecs[20].x_rvalid = 1'b1; vecs[21].x_rvalid = 1'b1;
    vecs[10].x_rdata = R0;
    for (int i = 11; i <= 20; i++) vecs[i].x_rdata = R1;
    for (int i = 21; i < NV; i++) vecs[i].x_rdata = R0;
    for (int i = 11; i <= 19; i++) vecs[i].x_idx = 1'b1;
    for (int i = 21; i < NV; i++) vecs[i].x_idx = 1'b1;
    for (int i = 12; i <= 21; i++) vecs[i].x_err = E0;
    for (int i = 22; i < NV; i++) vecs[i].x_err = G3;
    vecs[12].x_done = 1'b1;
    vecs[22].x_done = 1'b1;

    rst_n = 1'b0;
    drive(zero_vec);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", zero_vec);
    #2 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      check_outputs($sformatf("step%0d", i), vecs[i]);
      drive(vecs[i]);
    end

    // Asynchronous reset in the middle of the stream phase.
    @(posedge clk); #1;
    drive(zero_vec);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst_seq beat0", scaler, G1);
    @(posedge clk); #1;
    chk("rst_seq beat1", scaler, G3);
    #3 rst_n = 1'b0;
    #1 check_outputs("async_reset", zero_vec);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_reset%0d DONE", k), W'(done), '0);
      chk($sformatf("post_reset%0d BUSY", k), W'(busy), '0);
    end

    // Guesses were cleared by reset; a fresh run streams zeros then bias.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cleared beat0", scaler, '0);
    chk("cleared init", W'(init_flag), W'(1'b1));
    @(posedge clk); #1;
    chk("cleared beat1", scaler, '0);
    @(posedge clk); #1;
    chk("cleared beat2", scaler, BIAS);
    repeat (7) @(posedge clk);
    #1;
    chk("cleared run DONE", W'(done), W'(1'b1));
    chk("cleared run BUSY", W'(busy), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_stream_sequencer.md
# fwd_stream_sequencer

Sequencer that sits on both ends of the forward engine's serial interface. It holds the current guess vector X and streams it into the engine's `INPUT_SCALER` port one element per cycle, followed by the bias constant. It then collects the engine's serial `ACC_RESULT` outputs f_i(X) and the accumulated error, and presents them to the trainer with a valid/done handshake. The trainer updates X through a small write port between runs.

## Interface
- `NUM_UNKNOWNS`, 2: vector length N.
- `BIT_WIDTH`, 32: float width.
- `EXTRA_BITS`, 2: FloPoCo exception bits (0 or 2). W = BIT_WIDTH+EXTRA_BITS.
- `RESULT_LATENCY`, 6: cycles from beat 0 on `INPUT_SCALER` until f_0 appears on `ENGINE_RESULT`. Must be ≥ N+1.
- `BIAS_VALUE`, 34'h13F800000: FloPoCo +1.0, streamed as the last beat.
- `CLK` in 1: clock; all logic is on the rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `GUESS_WR_EN` in 1: write the guess register selected by `GUESS_WR_ADDR`.
- `GUESS_WR_ADDR` in clog2(N): guess index.
- `GUESS_WR_DATA` in W: guess value.
- `START` in 1: request one forward run.
- `INPUT_SCALER` out W: serial operand to the engine.
- `SCALER_VALID` out 1: `INPUT_SCALER` beat valid.
- `INITIAL_READ_FLAG` out 1: high on beat 0 only.
- `ENGINE_RESULT` in W: engine `ACC_RESULT`.
- `ENGINE_ERROR` in W: engine `ERROR_ACC_OUT`.
- `BUSY` out 1: run in progress.
- `RESULT_VALID` out 1: `RESULT_DATA`/`RESULT_IDX` valid.
- `RESULT_IDX` out clog2(N): function index i.
- `RESULT_DATA` out W: f_i(X).
- `ERROR_OUT` out W: error captured at the end of the last run; held until the next capture.
- `DONE` out 1: one-cycle pulse at the end of a run.
- `WR_DROP` out 1: one-cycle pulse when a guess write is rejected.

## Operation
- **States and transitions:**
  - IDLE → STREAM when `START`=1.
  - STREAM → WAIT after beat N.
  - WAIT → COLLECT when cyc = `RESULT_LATENCY`.
  - COLLECT → ERR after N captures.
  - ERR → IDLE.
- **Cycle counter:** cyc is 0 on beat 0 and increments every cycle while BUSY.
- **STREAM:** beat k (k < N) drives guess[k]; beat N drives `BIAS_VALUE`. `SCALER_VALID`=1 on every beat. Outside STREAM, `INPUT_SCALER`=0 and `SCALER_VALID`=0.
- **COLLECT:** at cyc = `RESULT_LATENCY`+k, sample `ENGINE_RESULT` into the output register. The next cycle shows `RESULT_VALID`=1, `RESULT_IDX`=k and `RESULT_DATA` = the sample.
- **ERR:** at cyc = `RESULT_LATENCY`+N, sample `ENGINE_ERROR` into `ERROR_OUT`. `DONE`=1 the following cycle, which is also the first cycle back in IDLE.
- **Guess writes:** accepted only when `BUSY`=0, with effect on the next edge. While `BUSY`=1 the write is dropped, guess registers are unchanged and `WR_DROP` pulses. A write in the same cycle as an accepted `START` is accepted and is used by that run, because beat 0 is the next cycle.
- **`START` while `BUSY`:** ignored, with no queuing.
- **Out-of-range `GUESS_WR_ADDR`** (≥ N): the write is ignored and `WR_DROP` pulses.
- **Reset:** asynchronous and active-low. It aborts any run with no `DONE`; guesses and the run are lost. Reset values:
  - state IDLE, cyc 0;
  - all guess registers 0;
  - `INPUT_SCALER`, `RESULT_DATA`, `ERROR_OUT` = 0;
  - `RESULT_IDX` = 0;
  - all 1-bit outputs = 0.
- **No arithmetic on data:** values pass through bit-exact. The counter width is clog2(`RESULT_LATENCY`+N+2).

## Timing
- `START` sampled at edge t:
  - `BUSY`=1 and beat 0 from t+1; beats at t+1 … t+N+1.
  - `BUSY` drops when `DONE` rises.
- Result i is valid at t+1+`RESULT_LATENCY`+i+1.
- `ERROR_OUT` updates at t+1+`RESULT_LATENCY`+N+1. `DONE` pulses at t+`RESULT_LATENCY`+N+2.
- Run length is `RESULT_LATENCY`+N+2 cycles. A new `START` is accepted in the `DONE` cycle, giving back-to-back runs.
- `RESULT_VALID` is asserted for exactly N consecutive cycles per run.

## Test plan
- **Reset:** assert `RESET`=0 mid-STREAM → all outputs 0 immediately, and no `DONE` pulse after release.
- **Basic run** (N=2, L=6): write guess0=34'h13F800000 (1.0) and guess1=34'h140000000 (2.0); `START` at t.
  - `INPUT_SCALER` = 1.0, 2.0, `BIAS_VALUE` at t+1..t+3.
  - `INITIAL_READ_FLAG` only at t+1.
- **Collect:** drive `ENGINE_RESULT`=34'h140400000 at t+7 and 34'h1C0800000 at t+8, and `ENGINE_ERROR`=34'h141500000 at t+9.
  - `RESULT_VALID` at t+8 with idx 0 and at t+9 with idx 1, data matching.
  - `ERROR_OUT`=34'h141500000 and `DONE` pulse at t+10.
- **Write while `BUSY`:** write guess0=0 at t+4 → `WR_DROP` pulse; the next run streams 1.0.
- **`START` during run and back-to-back:** `START` asserted at t+3 → ignored. `START` at t+10 → beat 0 at t+11.
- **Same-cycle write + `START`:** guess1=34'h140800000 with `START` at t → beat 1 at t+2 = 34'h140800000.
